// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the FPU single-precision
// normalize/round stage.
//   EXP_W, FRAC_W, MANT_W : exponent, stored fraction and extended mantissa widths
//   EXPX_W                : widened exponent used for overflow-free arithmetic
//   BIAS, EXP_MAX         : binary32 exponent bias and all-ones exponent
//   FLAG_*                : bit positions inside the 4-bit flags vector
//   s1_t                  : contents of the normalize-stage pipeline register
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;  // carry, hidden, fraction, guard, round, sticky
    localparam int EXPX_W  = EXP_W + 2;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    typedef struct packed {
        logic                     sign;
        logic signed [EXPX_W-1:0] exp;
        logic [MANT_W-1:0]        mant;
        logic                     zero;
        logic                     subnormal;
    } s1_t;

endpackage

// File: rtl/fp_lzc27.sv
// fp_lzc27: combinational 27-bit leading-zero counter.
//   data  : input vector, bit 26 is the most significant
//   count : number of leading zeros (27 when data is all zero)
// The vector is split into four 8-bit chunks, each handled by an 8-to-3
// priority encoder; the first chunk containing a one selects the result.
module fp_lzc27 (
    input  logic [26:0] data,
    output logic [4:0]  count
);

    logic [7:0] chunk [4];
    logic [2:0] pos   [4];
    logic [2:0] hit;

    // The last chunk is padded with ones so it always contains a one and the
    // all-zero input yields 24 + 3 = 27 without a separate invalid path.
    assign chunk[0] = data[26:19];
    assign chunk[1] = data[18:11];
    assign chunk[2] = data[10:3];
    assign chunk[3] = {data[2:0], 5'b11111};

    assign hit[0] = |chunk[0];
    assign hit[1] = |chunk[1];
    assign hit[2] = |chunk[2];

    // 8-to-3 priority encoders: distance of the highest set bit from bit 7.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            // NOTE: every combinational output gets a default before any
            // conditional update, otherwise synthesis infers a latch.
            pos[c] = 3'd7;
            for (int i = 0; i < 8; i++) begin
                if (chunk[c][i]) begin
                    pos[c] = 3'(7 - i);
                end
            end
        end
    end

    always_comb begin
        if (hit[0]) begin
            count = {2'b00, pos[0]};
        end else if (hit[1]) begin
            count = {2'b01, pos[1]};
        end else if (hit[2]) begin
            count = {2'b10, pos[2]};
        end else begin
            count = {2'b11, pos[3]};
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize and round-to-nearest-even stage of the
// single-precision add/sub datapath, with a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream handshake
//   in_sign            : result sign
//   in_exp             : biased exponent referenced to the hidden-bit position
//   in_mant            : [27] carry, [26] hidden, [25:3] fraction, [2] g, [1] r, [0] s
//   out_valid/out_ready: downstream handshake
//   out_result         : packed binary32 result
//   out_flags          : {overflow, underflow, inexact, zero}
// Build option: define FP_FLUSH_DENORM_EN to flush subnormal or underflowing
// results to signed zero; by default results underflow gradually.
module fp_norm_round
    import fpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W-1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic [3:0]                out_flags
);

    logic             s1_valid;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             s2_ready;

    // Each stage loads when empty or when its contents leave this cycle.
    assign s2_ready = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_ready;

    // ---------------- Stage 1: normalize ----------------
    logic [4:0]        lzc;
    logic [4:0]        shamt;
    logic [EXPX_W-1:0] exp_in;
    logic [EXPX_W-1:0] exp_limit;
    logic [MANT_W-1:0] mant_sh;

    fp_lzc27 u_lzc (
        .data  (in_mant[26:0]),
        .count (lzc)
    );

    assign exp_in    = {2'b00, in_exp};
    assign exp_limit = exp_in - EXPX_W'(1);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        shamt     = '0;
        mant_sh   = '0;
        if (in_mant == '0) begin
            s1_d.zero = 1'b1;
        end else if (in_mant[MANT_W-1]) begin
            // Carry out of the add: shift right once, folding r and s into sticky.
            s1_d.mant = {1'b0, in_mant[27:3], in_mant[2], in_mant[1] | in_mant[0]};
            s1_d.exp  = exp_in + EXPX_W'(1);
        end else begin
            // Never shift further than exponent 1 allows; anything left over
            // stays subnormal.
            if (in_exp != '0) begin
                if ({{(EXPX_W-5){1'b0}}, lzc} <= exp_limit) begin
                    shamt = lzc;
                end else begin
                    shamt = exp_limit[4:0];
                end
            end
            mant_sh   = {1'b0, in_mant[26:0] << shamt};
            s1_d.mant = mant_sh;
            s1_d.exp  = exp_in - {{(EXPX_W-5){1'b0}}, shamt};
            if (!mant_sh[26]) begin
                s1_d.subnormal = 1'b1;
                s1_d.exp       = '0;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the payload register carries no reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_q <= s1_d;
        end
    end

    // ---------------- Stage 2: round to nearest even ----------------
    logic              g_bit, r_bit, s_bit, lsb, round_up;
    logic [FRAC_W+1:0] sig;
    logic [EXPX_W-1:0] exp_r;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;
    logic              ovf, unf, inx, zf;

    always_comb begin
        lsb      = s1_q.mant[3];
        g_bit    = s1_q.mant[2];
        r_bit    = s1_q.mant[1];
        s_bit    = s1_q.mant[0];
        round_up = g_bit & (r_bit | s_bit | lsb);
        inx      = g_bit | r_bit | s_bit;
        sig      = s1_q.mant[MANT_W-1:3] + {{(FRAC_W+1){1'b0}}, round_up};
        exp_r    = s1_q.exp;
        frac     = sig[FRAC_W-1:0];
        ovf      = 1'b0;
        unf      = 1'b0;
        if (sig[FRAC_W+1]) begin
            // Rounding carried past the hidden bit.
            exp_r = exp_r + EXPX_W'(1);
            frac  = sig[FRAC_W:1];
        end else if (s1_q.subnormal && sig[FRAC_W]) begin
            // Largest subnormal rounded up to the smallest normal.
            exp_r = EXPX_W'(1);
        end
        exp_f = exp_r[EXP_W-1:0];
        if (s1_q.zero) begin
            exp_f = '0;
            frac  = '0;
        end else if (exp_r >= EXPX_W'(EXP_MAX)) begin
            ovf   = 1'b1;
            inx   = 1'b1;
            exp_f = '1;
            frac  = '0;
        end
`ifdef FP_FLUSH_DENORM_EN
        if (exp_f == '0 && (frac != '0 || inx)) begin
            frac = '0;
            unf  = 1'b1;
            inx  = 1'b1;
        end
`else
        unf = (exp_f == '0) && (frac != '0) && inx;
`endif
        zf = ({exp_f, frac} == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result           <= {s1_q.sign, exp_f, frac};
                out_flags[FLAG_OVF]  <= ovf;
                out_flags[FLAG_UNF]  <= unf;
                out_flags[FLAG_INX]  <= inx;
                out_flags[FLAG_ZERO] <= zf;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed bench for fp_norm_round. Expected results are
// queued when an input is accepted and compared when the output transfers.
module tb_fp_norm_round;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    fp_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

`ifdef FP_FLUSH_DENORM_EN
    localparam logic [31:0] SUB_RES  = 32'h0000_0000;
    localparam logic [3:0]  SUB_FL   = 4'b0111;
    localparam logic [31:0] UNF_RES  = 32'h0000_0000;
    localparam logic [3:0]  UNF_FL   = 4'b0111;
`else
    localparam logic [31:0] SUB_RES  = 32'h0008_0000;
    localparam logic [3:0]  SUB_FL   = 4'b0000;
    localparam logic [31:0] UNF_RES  = 32'h0040_0000;
    localparam logic [3:0]  UNF_FL   = 4'b0110;
`endif

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   fails    = 0;
    int   accepted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one input from posedge+1 and hold it until accepted.
    task automatic send(input logic sign, input logic [7:0] e, input logic [27:0] m,
                        input logic [31:0] res, input logic [3:0] fl, input string tag);
        exp_t item;
        bit   done = 1'b0;
        in_valid   = 1'b1;
        in_sign    = sign;
        in_exp     = e;
        in_mant    = m;
        item.res   = res;
        item.flags = fl;
        item.tag   = tag;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(item);
                accepted++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compare on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_result"}, out_result, e.res);
                    check({e.tag, "_flags"}, {28'b0, out_flags}, {28'b0, e.flags});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_flags", {28'b0, out_flags}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, streamed back to back.
        send(1'b0, 8'h80, 28'hC000000, 32'h40C0_0000, 4'b0000, "carry");
        send(1'b0, 8'h85, 28'h0100000, 32'h3F80_0000, 4'b0000, "cancel");
        send(1'b0, 8'h7F, 28'h4000004, 32'h3F80_0000, 4'b0010, "tie_even");
        send(1'b0, 8'h7F, 28'h400000C, 32'h3F80_0002, 4'b0010, "tie_odd");
        send(1'b0, 8'h7F, 28'h4000005, 32'h3F80_0001, 4'b0010, "above_half");
        send(1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F80_0000, 4'b1010, "round_ovf");
        send(1'b1, 8'hFE, 28'h8000000, 32'hFF80_0000, 4'b1010, "carry_ovf");
        send(1'b1, 8'h40, 28'h0000000, 32'h8000_0000, 4'b0001, "neg_zero");
        send(1'b0, 8'h03, 28'h0100000, SUB_RES,       SUB_FL,  "subnormal");
        send(1'b0, 8'h01, 28'h2000002, UNF_RES,       UNF_FL,  "underflow");
        send(1'b0, 8'h01, 28'h3FFFFFE, 32'h0080_0000, 4'b0010, "sub_to_norm");
        send(1'b0, 8'h80, 28'h8000003, 32'h4080_0000, 4'b0010, "carry_sticky");
        in_valid = 1'b0;
        drain("directed");

        // Back-pressure: four inputs against a stalled output.
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                send(1'b0, 8'h80, 28'hC000000, 32'h40C0_0000, 4'b0000, "bp0");
                send(1'b0, 8'h85, 28'h0100000, 32'h3F80_0000, 4'b0000, "bp1");
                send(1'b0, 8'h7F, 28'h400000C, 32'h3F80_0002, 4'b0010, "bp2");
                send(1'b0, 8'h7F, 28'h4000005, 32'h3F80_0001, 4'b0010, "bp3");
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_accepted", 32'(accepted), 32'd2);
                check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                check("bp_out_valid", {31'b0, out_valid}, 32'd1);
                check("bp_held_result", out_result, 32'h40C0_0000);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("bp_total_accepted", 32'(accepted), 32'd4);

        // Reset while stalled discards everything in flight.
        out_ready = 1'b0;
        send(1'b0, 8'h80, 28'hC000000, 32'h40C0_0000, 4'b0000, "rs0");
        send(1'b0, 8'h85, 28'h0100000, 32'h3F80_0000, 4'b0000, "rs1");
        in_valid = 1'b0;
        @(negedge clk);
        check("rs_stalled_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rs_out_valid", {31'b0, out_valid}, 32'd0);
        check("rs_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(1'b0, 8'h7F, 28'h4000004, 32'h3F80_0000, 4'b0010, "post_reset");
        in_valid = 1'b0;
        drain("post_reset");
        repeat (4) @(negedge clk);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
